pwm_ramp: RTL and testbench

PWM_RAMP -- requirements
Module: pwm_ramp

---
 rtl/pwm_ramp.sv | 119 +++++++++++
 tb/tb_pwm_ramp.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp.sv
// Duty-cycle ramp generator: steps a registered duty value toward an accepted
// target by STEP every DIV clocks, pulsing done when the target is reached.
module pwm_ramp #(
  parameter int LEN  = 8,
  parameter int DIV  = 1000,
  parameter int STEP = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [LEN-1:0] tgt,
  input  logic           tgt_valid,
  output logic           tgt_ready,
  output logic [LEN-1:0] val,
  output logic           busy,
  output logic           done
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RAMP = 1'b1
  } state_e;

  localparam logic [15:0]  DIV_M1 = 16'(DIV - 1);
  localparam logic [LEN-1:0] STEP_L = LEN'(STEP);
  localparam logic [LEN:0]   STEP_W = (LEN+1)'(STEP);

  state_e         state_q, state_d;
  logic [LEN-1:0] val_q, val_d;
  logic [LEN-1:0] tgt_q, tgt_d;
  logic [15:0]    cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [LEN:0]   diff_up_s, diff_dn_s, mag_s;
  logic           up_s, near_s, tick_s;

  // Distance to target in LEN+1 bits so the final step can never wrap val.
  always_comb begin
    up_s      = (tgt_q > val_q);
    diff_up_s = {1'b0, tgt_q} - {1'b0, val_q};
    diff_dn_s = {1'b0, val_q} - {1'b0, tgt_q};
    mag_s     = up_s ? diff_up_s : diff_dn_s;
    near_s    = (mag_s <= STEP_W);
    tick_s    = (cnt_q == DIV_M1);
  end

  // Next-state and datapath decode for the IDLE/RAMP controller.
  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tgt_valid) begin
          tgt_d = tgt;
          if (tgt != val_q) begin
            state_d = S_RAMP;
            cnt_d   = 16'd0;
            busy_d  = 1'b1;
          end else begin
            // A back-to-back equal accept is absorbed so done never stretches.
            done_d = ~done_q;
          end
        end else begin
          tgt_d = tgt_q;
        end
      end
      S_RAMP: begin
        if (tick_s) begin
          cnt_d = 16'd0;
          if (near_s) begin
            val_d   = tgt_q;
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (up_s) begin
            val_d = val_q + STEP_L;
          end else begin
            val_d = val_q - STEP_L;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      val_q   <= '0;
      tgt_q   <= '0;
      cnt_q   <= 16'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tgt_ready = (state_q == S_IDLE);
  assign val       = val_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pwm_ramp.sv
// Directed bench for pwm_ramp: one instance with DIV=4/STEP=1, one with DIV=1/STEP=16.
module tb_pwm_ramp;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] a_tgt = 8'd0, b_tgt = 8'd0;
  logic       a_valid = 1'b0, b_valid = 1'b0;
  logic [7:0] a_val, b_val;
  logic       a_ready, b_ready, a_busy, b_busy, a_done, b_done;
  int         tests = 0;
  int         failed = 0;

  always #5 clk = ~clk;

  pwm_ramp #(.LEN(8), .DIV(4), .STEP(1)) u_a (
    .clk(clk), .rst(rst), .tgt(a_tgt), .tgt_valid(a_valid), .tgt_ready(a_ready),
    .val(a_val), .busy(a_busy), .done(a_done));

  pwm_ramp #(.LEN(8), .DIV(1), .STEP(16)) u_b (
    .clk(clk), .rst(rst), .tgt(b_tgt), .tgt_valid(b_valid), .tgt_ready(b_ready),
    .val(b_val), .busy(b_busy), .done(b_done));

  task automatic acc_a(input logic [7:0] v);
    @(negedge clk); a_tgt = v; a_valid = 1'b1;
    @(negedge clk); a_valid = 1'b0;
  endtask

  task automatic acc_b(input logic [7:0] v);
    @(negedge clk); b_tgt = v; b_valid = 1'b1;
    @(negedge clk); b_valid = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    tests++; if ({a_val, a_busy, a_done, a_ready} !== {8'd0, 1'b0, 1'b0, 1'b1}) begin
      failed++; $display("FAIL reset_a got val=%0d busy=%b done=%b rdy=%b exp 0 0 0 1", a_val, a_busy, a_done, a_ready); end
    tests++; if ({b_val, b_busy, b_done, b_ready} !== {8'd0, 1'b0, 1'b0, 1'b1}) begin
      failed++; $display("FAIL reset_b got val=%0d busy=%b done=%b rdy=%b exp 0 0 0 1", b_val, b_busy, b_done, b_ready); end
    // first accept on the very first edge after reset release
    @(negedge clk); rst = 1'b1; b_tgt = 8'd128; b_valid = 1'b1;
    @(negedge clk); b_valid = 1'b0;
    tests++; if ({b_busy, b_ready, b_val} !== {1'b1, 1'b0, 8'd0}) begin
      failed++; $display("FAIL first_accept got busy=%b rdy=%b val=%0d exp 1 0 0", b_busy, b_ready, b_val); end
    repeat (8) @(negedge clk);
    tests++; if ({b_val, b_done, b_busy} !== {8'd128, 1'b1, 1'b0}) begin
      failed++; $display("FAIL first_ramp got val=%0d done=%b busy=%b exp 128 1 0", b_val, b_done, b_busy); end
  endtask

  task automatic test_ramp_up;
    logic [7:0] ev;
    acc_a(8'd128);
    tests++; if ({a_busy, a_ready, a_val} !== {1'b1, 1'b0, 8'd0}) begin
      failed++; $display("FAIL up_accept got busy=%b rdy=%b val=%0d exp 1 0 0", a_busy, a_ready, a_val); end
    for (int n = 1; n <= 513; n++) begin
      @(negedge clk);
      ev = (n >= 512) ? 8'd128 : 8'(n / 4);
      tests++; if (a_val !== ev) begin
        failed++; $display("FAIL up_val edge %0d got %0d exp %0d", n, a_val, ev); end
      tests++; if (a_busy !== (n < 512) || a_done !== (n == 512)) begin
        failed++; $display("FAIL up_flags edge %0d got busy=%b done=%b exp %b %b", n, a_busy, a_done, n < 512, n == 512); end
    end
  endtask

  task automatic test_ramp_down;
    logic [7:0] seq [7] = '{8'd112, 8'd96, 8'd80, 8'd64, 8'd48, 8'd32, 8'd30};
    acc_b(8'd30);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      tests++; if (b_val !== seq[i] || b_done !== (i == 6) || b_busy !== (i < 6)) begin
        failed++; $display("FAIL down tick %0d got val=%0d done=%b busy=%b exp %0d %b %b",
                           i + 1, b_val, b_done, b_busy, seq[i], i == 6, i < 6); end
    end
    @(negedge clk);
    tests++; if ({b_val, b_done} !== {8'd30, 1'b0}) begin
      failed++; $display("FAIL down_hold got val=%0d done=%b exp 30 0", b_val, b_done); end
  endtask

  task automatic test_equal;
    acc_b(8'd30);
    tests++; if ({b_busy, b_done, b_val, b_ready} !== {1'b0, 1'b1, 8'd30, 1'b1}) begin
      failed++; $display("FAIL equal got busy=%b done=%b val=%0d rdy=%b exp 0 1 30 1", b_busy, b_done, b_val, b_ready); end
    @(negedge clk);
    tests++; if ({b_done, b_val} !== {1'b0, 8'd30}) begin
      failed++; $display("FAIL equal_pulse got done=%b val=%0d exp 0 30", b_done, b_val); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk); b_tgt = 8'd30; b_valid = 1'b1;
    @(negedge clk);
    tests++; if (b_done !== 1'b1) begin
      failed++; $display("FAIL b2b_first got done=%b exp 1", b_done); end
    @(negedge clk); b_valid = 1'b0;
    tests++; if (b_done !== 1'b0) begin
      failed++; $display("FAIL b2b_second got done=%b exp 0", b_done); end
  endtask

  task automatic test_wrap;
    logic [7:0] ev;
    acc_b(8'd0);
    @(negedge clk);
    tests++; if (b_val !== 8'd14) begin
      failed++; $display("FAIL floor_step got %0d exp 14", b_val); end
    @(negedge clk);
    tests++; if ({b_val, b_done} !== {8'd0, 1'b1}) begin
      failed++; $display("FAIL floor_end got val=%0d done=%b exp 0 1", b_val, b_done); end
    acc_b(8'd255);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      ev = (i == 16) ? 8'd255 : 8'(16 * i);
      tests++; if (b_val !== ev || b_done !== (i == 16)) begin
        failed++; $display("FAIL ceil tick %0d got val=%0d done=%b exp %0d %b", i, b_val, b_done, ev, i == 16); end
    end
  endtask

  task automatic test_ignore;
    logic [7:0] ev;
    acc_a(8'd20);
    for (int n = 1; n <= 432; n++) begin
      @(negedge clk);
      ev = 8'(128 - n / 4);
      tests++; if (a_val !== ev || a_ready !== (n == 432) || a_done !== (n == 432)) begin
        failed++; $display("FAIL ignore edge %0d got val=%0d rdy=%b done=%b exp %0d %b %b",
                           n, a_val, a_ready, a_done, ev, n == 432, n == 432); end
      a_tgt = 8'd0;
      a_valid = (n >= 10 && n <= 12);
    end
    a_valid = 1'b0;
    @(negedge clk);
    tests++; if ({a_val, a_done, a_busy} !== {8'd20, 1'b0, 1'b0}) begin
      failed++; $display("FAIL ignore_hold got val=%0d done=%b busy=%b exp 20 0 0", a_val, a_done, a_busy); end
  endtask

  task automatic test_abort;
    acc_a(8'd200);
    repeat (6) @(negedge clk);
    tests++; if (a_val !== 8'd21) begin
      failed++; $display("FAIL abort_pre got %0d exp 21", a_val); end
    #2 rst = 1'b0;
    #1;
    tests++; if ({a_val, a_busy, a_done, a_ready} !== {8'd0, 1'b0, 1'b0, 1'b1}) begin
      failed++; $display("FAIL abort_async got val=%0d busy=%b done=%b rdy=%b exp 0 0 0 1", a_val, a_busy, a_done, a_ready); end
    @(negedge clk); rst = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      tests++; if ({a_val, a_done, a_busy} !== {8'd0, 1'b0, 1'b0}) begin
        failed++; $display("FAIL abort_quiet cycle %0d got val=%0d done=%b busy=%b exp 0 0 0", n, a_val, a_done, a_busy); end
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_equal();
    test_back_to_back();
    test_wrap();
    test_ignore();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
